// File: rtl/button_debouncer.sv
// button_debouncer: turns a raw, bouncing push-button level into a clean
// registered level, one-cycle rise/fall pulses and a press-toggle bit.
// A new level is accepted only after BOUNCE_TICKS consecutive tick-qualified
// samples agree with it; any opposite sample in between discards progress.
module button_debouncer #(
  parameter int BOUNCE_TICKS  = 4,
  parameter int COUNTER_WIDTH = $clog2(BOUNCE_TICKS) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  input  logic tick,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic toggle
);

  typedef enum logic [1:0] {
    S_LOW        = 2'd0,
    S_MAYBE_HIGH = 2'd1,
    S_HIGH       = 2'd2,
    S_MAYBE_LOW  = 2'd3
  } state_e;

  // Count value on which the next tick-qualified sample accepts the new level.
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(BOUNCE_TICKS - 1);

  logic                     sync1_q;
  logic                     sync2_q;
  state_e                   state_q;
  state_e                   state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic [COUNTER_WIDTH-1:0] cnt_d;
  logic                     debounced_q;
  logic                     debounced_d;
  logic                     rise_q;
  logic                     rise_d;
  logic                     fall_q;
  logic                     fall_d;
  logic                     toggle_q;
  logic                     toggle_d;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOW;
      cnt_q       <= '0;
      debounced_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      toggle_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      debounced_q <= debounced_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      toggle_q    <= toggle_d;
    end
  end

  // Next-state logic: enter a MAYBE state on the first opposite sample, count
  // tick-qualified agreeing samples there, and fall back on any bounce.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;

    case (state_q)
      S_LOW: begin
        if (sync2_q) begin
          state_d = S_MAYBE_HIGH;
          cnt_d   = '0;
        end
      end

      S_MAYBE_HIGH: begin
        if (!sync2_q) begin
          // Bounce: discard progress regardless of tick.
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d  = S_HIGH;
            cnt_d    = '0;
            rise_d   = 1'b1;
            toggle_d = ~toggle_q;
          end else begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
          end
        end
      end

      S_HIGH: begin
        if (!sync2_q) begin
          state_d = S_MAYBE_LOW;
          cnt_d   = '0;
        end
      end

      S_MAYBE_LOW: begin
        if (sync2_q) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase

    // The accepted level stays high until a release has been confirmed.
    debounced_d = (state_d == S_HIGH) || (state_d == S_MAYBE_LOW);
  end

  assign debounced = debounced_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign toggle    = toggle_q;

endmodule
